// File: rtl/spi_gyro_responder.sv
// SPI mode-3 responder emulating the PmodGYRO register map.
// All SPI pins are resynchronised into clk and handled by edge detection, so the
// SPI clock must be slow compared to clk (half-period >= SYNC_STAGES+2 clk).
module spi_gyro_responder #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] x_axis_in,
    input  logic [15:0] y_axis_in,
    input  logic [15:0] z_axis_in,
    input  logic [7:0]  temp_in,
    output logic [7:0]  ctrl_reg1,
    output logic        wr_strobe,
    output logic        txn_done
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr, tx_sr, cmd_byte, rd_data;
    logic                   miso_q, rw, ms;
    logic [5:0]             addr, nxt_addr, rd_addr;
    logic [15:0]            x_sh, y_sh, z_sh;
    logic [7:0]             t_sh;
    logic [7:0]             ctrl2, ctrl3, ctrl4, ctrl5;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cmd_byte  = {rx_sr[6:0], mosi_s};
    assign nxt_addr  = ms ? addr + 6'd1 : addr;
    assign rd_addr   = (state == CMD) ? cmd_byte[5:0] : nxt_addr;
    assign miso      = miso_q & (state != IDLE);
    assign miso_oe   = ~cs_s;

    // Synchronisers and previous-value flops; idle levels avoid false edges out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state; cs release overrides everything
    always_comb begin
        state_nxt = state;
        if (cs_rise) state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = CMD;
                CMD:     if (sclk_rise && bit_cnt == 3'd7) state_nxt = DATA;
                default: state_nxt = state;
            endcase
        end
    end

    // Read mux over the snapshot bank and control registers
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            6'h0F:   rd_data = WHO_AM_I_VAL;
            6'h20:   rd_data = ctrl_reg1;
            6'h21:   rd_data = ctrl2;
            6'h22:   rd_data = ctrl3;
            6'h23:   rd_data = ctrl4;
            6'h24:   rd_data = ctrl5;
            6'h26:   rd_data = t_sh;
            6'h28:   rd_data = x_sh[7:0];
            6'h29:   rd_data = x_sh[15:8];
            6'h2A:   rd_data = y_sh[7:0];
            6'h2B:   rd_data = y_sh[15:8];
            6'h2C:   rd_data = z_sh[7:0];
            6'h2D:   rd_data = z_sh[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    // Shift registers, command decode, register writes and strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            miso_q    <= 1'b0;
            rw        <= 1'b0;
            ms        <= 1'b0;
            addr      <= '0;
            x_sh      <= '0;
            y_sh      <= '0;
            z_sh      <= '0;
            t_sh      <= '0;
            ctrl_reg1 <= CTRL1_RST;
            ctrl2     <= '0;
            ctrl3     <= '0;
            ctrl4     <= '0;
            ctrl5     <= '0;
            wr_strobe <= 1'b0;
            txn_done  <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            txn_done  <= cs_rise;
            if (cs_rise) begin
                bit_cnt <= '0;
                tx_sr   <= '0;
                miso_q  <= 1'b0;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    x_sh    <= x_axis_in;
                    y_sh    <= y_axis_in;
                    z_sh    <= z_axis_in;
                    t_sh    <= temp_in;
                    bit_cnt <= '0;
                    tx_sr   <= '0;
                    miso_q  <= 1'b0;
                end
            end else if (sclk_rise) begin
                rx_sr   <= cmd_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == CMD) begin
                        rw    <= cmd_byte[7];
                        ms    <= cmd_byte[6];
                        addr  <= cmd_byte[5:0];
                        tx_sr <= cmd_byte[7] ? rd_data : 8'h00;
                    end else begin
                        addr <= nxt_addr;
                        if (rw) tx_sr <= rd_data;
                        else begin
                            case (addr)
                                6'h20: begin ctrl_reg1 <= cmd_byte; wr_strobe <= 1'b1; end
                                6'h21: begin ctrl2 <= cmd_byte; wr_strobe <= 1'b1; end
                                6'h22: begin ctrl3 <= cmd_byte; wr_strobe <= 1'b1; end
                                6'h23: begin ctrl4 <= cmd_byte; wr_strobe <= 1'b1; end
                                6'h24: begin ctrl5 <= cmd_byte; wr_strobe <= 1'b1; end
                                default: ;
                            endcase
                        end
                    end
                end
            end else if (sclk_fall) begin
                miso_q <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_gyro_responder.sv
// Directed bench for spi_gyro_responder: bit-banged SPI mode-3 master.
module tb_spi_gyro_responder;
    localparam int HALF = 80;  // sclk half-period in ns (8 clk cycles)

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b1;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, wr_strobe, txn_done;
    logic [15:0] x_axis_in = 16'h0, y_axis_in = 16'h0, z_axis_in = 16'h0;
    logic [7:0]  temp_in = 8'h0;
    logic [7:0]  ctrl_reg1;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int n_done = 0;

    spi_gyro_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .x_axis_in(x_axis_in), .y_axis_in(y_axis_in), .z_axis_in(z_axis_in),
        .temp_in(temp_in), .ctrl_reg1(ctrl_reg1),
        .wr_strobe(wr_strobe), .txn_done(txn_done)
    );

    always #5 clk = ~clk;

    // Pulse monitors
    always @(posedge clk) begin
        if (wr_strobe) n_wr++;
        if (txn_done)  n_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = tx[7-i];
            #HALF;
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            #HALF;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        cs = 1'b1;
        #HALF;
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] exp3 [6];
        int         base_wr, base_done;

        exp3 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};

        // Reset values
        @(posedge clk); #2;
        #30;
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_txn_done", txn_done, 0);
        check("rst_ctrl1", ctrl_reg1, 8'h07);
        rst = 1'b1;
        #40;

        // 1: WHO_AM_I read
        base_done = n_done;
        cs_low();
        check("t1_miso_oe", miso_oe, 1);
        spi_bits(8'h8F, 8, rx);
        check("t1_cmd_miso0", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        check("t1_whoami", rx, 8'hD3);
        cs_high();
        check("t1_txn_done", n_done - base_done, 1);
        check("t1_miso_oe_off", miso_oe, 0);

        // 2: write CTRL_REG1 then read back
        base_wr = n_wr;
        cs_low();
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h0F, 8, rx);
        cs_high();
        check("t2_ctrl1", ctrl_reg1, 8'h0F);
        check("t2_wr_cnt", n_wr - base_wr, 1);
        cs_low();
        spi_bits(8'hA0, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_high();
        check("t2_readback", rx, 8'h0F);

        // 3: burst read of all axes
        x_axis_in = 16'h1234; y_axis_in = 16'hABCD; z_axis_in = 16'h8001;
        cs_low();
        spi_bits(8'hE8, 8, rx);
        for (int i = 0; i < 6; i++) begin
            spi_bits(8'h00, 8, rx);
            check($sformatf("t3_byte%0d", i), rx, exp3[i]);
        end
        cs_high();

        // 4: snapshot holds across L/H bytes
        cs_low();
        spi_bits(8'hE8, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("t4_byte0", rx, 8'h34);
        x_axis_in = 16'hFFFF;
        spi_bits(8'h00, 8, rx);
        check("t4_byte1", rx, 8'h12);
        cs_high();
        x_axis_in = 16'h1234;

        // 5: RO write ignored, aborted write discarded (fresh reset for CTRL1_RST)
        rst = 1'b0; #40; rst = 1'b1; #40;
        base_wr = n_wr;
        base_done = n_done;
        cs_low();
        spi_bits(8'h28, 8, rx);
        spi_bits(8'h55, 8, rx);
        cs_high();
        cs_low();
        spi_bits(8'h20, 8, rx);
        spi_bits(8'hAA, 4, rx);
        cs_high();
        check("t5_no_strobe", n_wr - base_wr, 0);
        check("t5_ctrl1", ctrl_reg1, 8'h07);
        check("t5_done_cnt", n_done - base_done, 2);
        cs_low();
        spi_bits(8'hA8, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_high();
        check("t5_xl", rx, 8'h34);

        // 6: address wrap 0x3F -> 0x00, then reset mid-byte
        cs_low();
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h00, 8, rx);
        check("t6_addr3f", rx, 8'h00);
        spi_bits(8'h00, 8, rx);
        check("t6_addr00", rx, 8'h00);
        cs_high();
        cs_low();
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h3C, 8, rx);
        cs_high();
        check("t6_ctrl1_wr", ctrl_reg1, 8'h3C);
        cs_low();
        spi_bits(8'h8F, 8, rx);
        spi_bits(8'h00, 4, rx);
        rst = 1'b0;
        #20;
        check("t6_rst_miso", miso, 0);
        check("t6_rst_miso_oe", miso_oe, 0);
        check("t6_rst_ctrl1", ctrl_reg1, 8'h07);
        check("t6_rst_strobe", wr_strobe, 0);
        check("t6_rst_done", txn_done, 0);
        cs = 1'b1;
        #20;
        rst = 1'b1;
        #40;
        cs_low();
        spi_bits(8'h8F, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_high();
        check("t6_whoami", rx, 8'hD3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
